// File: rtl/fb_pkg.sv
// Shared constants and types for the 640x480 4-bit framebuffer subsystem.
package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADR_W  = 19;
    localparam int FB_DAT_W  = 4;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_FILL,
        CLR_DONE
    } clr_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Full-screen clear engine: walks every pixel address once, writing a latched
// fill colour whenever the arbiter grants it the RAM port.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int WORD_DEPTH = FB_DEPTH,
    parameter int ADR_W      = FB_ADR_W,
    parameter int DAT_W      = FB_DAT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DAT_W-1:0] i_color,
    input  logic             i_grant,
    output logic             o_req,
    output logic [ADR_W-1:0] o_adr,
    output logic [DAT_W-1:0] o_dat,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(WORD_DEPTH - 1);

    clr_state_t       r_state;
    logic [ADR_W-1:0] r_cnt;
    logic [DAT_W-1:0] r_color;
    logic             r_req;
    logic             r_busy;
    logic             r_done;

    // Clear FSM; start is only honoured from IDLE, the counter advances on grants only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLR_IDLE;
            r_cnt   <= '0;
            r_color <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLR_IDLE: begin
                    if (i_start) begin
                        r_state <= CLR_FILL;
                        r_cnt   <= '0;
                        r_color <= i_color;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                CLR_FILL: begin
                    if (i_grant) begin
                        if (r_cnt == LAST_ADR) begin
                            r_state <= CLR_DONE;
                            r_req   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                CLR_DONE: begin
                    r_state <= CLR_IDLE;
                end
                default: begin
                    r_state <= CLR_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req  = r_req;
    assign o_adr  = r_cnt;
    assign o_dat  = r_color;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer RAM arbiter: video reads first, then CPU writes and
// clear-engine writes sharing the port round-robin.
// Optional build macro FB_STALL_STATS_EN adds a saturating CPU stall counter.
module fb_access_arbiter
    import fb_pkg::*;
#(
    parameter int WORD_DEPTH = FB_DEPTH,
    parameter int ADR_W      = FB_ADR_W,
    parameter int DAT_W      = FB_DAT_W
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             vid_req,
    input  logic [ADR_W-1:0] vid_adr,
    output logic             vid_ack,
    output logic             vid_valid,
    output logic [DAT_W-1:0] vid_dat,
    input  logic             cpu_req,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [DAT_W-1:0] cpu_dat,
    output logic             cpu_ack,
    input  logic             clr_start,
    input  logic [DAT_W-1:0] clr_color,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             adr_err,
    output logic             ram_we,
    output logic             ram_re,
    output logic [ADR_W-1:0] ram_adr,
    output logic [DAT_W-1:0] ram_dat_o,
    input  logic [DAT_W-1:0] ram_dat_i
`ifdef FB_STALL_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [31:0]      cpu_stall_cnt
`endif
);

    localparam logic [ADR_W-1:0] DEPTH_ADR = ADR_W'(WORD_DEPTH);

    logic             w_vid_gnt;
    logic             w_cpu_gnt;
    logic             w_clr_gnt;
    logic             w_clr_req;
    logic             w_cpu_in_range;
    logic [ADR_W-1:0] w_clr_adr;
    logic [DAT_W-1:0] w_clr_dat;
    logic [ADR_W-1:0] r_ram_adr;
    logic [DAT_W-1:0] r_ram_dat;
    logic             r_rr_cpu_first;
    logic             r_vid_valid;
    logic             r_adr_err;

    fb_clear_engine #(
        .WORD_DEPTH(WORD_DEPTH),
        .ADR_W     (ADR_W),
        .DAT_W     (DAT_W)
    ) u_clear (
        .i_clk  (clk_i),
        .i_rst  (rst),
        .i_start(clr_start),
        .i_color(clr_color),
        .i_grant(w_clr_gnt),
        .o_req  (w_clr_req),
        .o_adr  (w_clr_adr),
        .o_dat  (w_clr_dat),
        .o_busy (clr_busy),
        .o_done (clr_done)
    );

    assign w_cpu_in_range = (cpu_adr < DEPTH_ADR);

    // Grant selection: video always wins, otherwise CPU/clear by round-robin; nothing during reset.
    always_comb begin
        w_vid_gnt = 1'b0;
        w_cpu_gnt = 1'b0;
        w_clr_gnt = 1'b0;
        if (!rst) begin
            if (vid_req) begin
                w_vid_gnt = 1'b1;
            end else if (cpu_req && w_clr_req) begin
                if (r_rr_cpu_first) w_cpu_gnt = 1'b1;
                else                w_clr_gnt = 1'b1;
            end else if (cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (w_clr_req) begin
                w_clr_gnt = 1'b1;
            end
        end
    end

    // RAM port mux; address and write data hold their previous value when no write/read uses them.
    always_comb begin
        ram_re    = w_vid_gnt;
        ram_we    = w_clr_gnt | (w_cpu_gnt & w_cpu_in_range);
        ram_adr   = r_ram_adr;
        ram_dat_o = r_ram_dat;
        if (w_vid_gnt) begin
            ram_adr = vid_adr;
        end else if (w_clr_gnt) begin
            ram_adr   = w_clr_adr;
            ram_dat_o = w_clr_dat;
        end else if (w_cpu_gnt && w_cpu_in_range) begin
            ram_adr   = cpu_adr;
            ram_dat_o = cpu_dat;
        end
    end

    // Remember the last driven address/data so idle cycles keep the bus stable.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_ram_adr <= '0;
            r_ram_dat <= '0;
        end else begin
            r_ram_adr <= ram_adr;
            r_ram_dat <= ram_dat_o;
        end
    end

    // Round-robin pointer, read-valid pipeline stage and sticky address-error flag.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_rr_cpu_first <= 1'b1;
            r_vid_valid    <= 1'b0;
            r_adr_err      <= 1'b0;
        end else begin
            r_vid_valid <= w_vid_gnt;
            if (w_cpu_gnt)      r_rr_cpu_first <= 1'b0;
            else if (w_clr_gnt) r_rr_cpu_first <= 1'b1;
            if (w_cpu_gnt && !w_cpu_in_range) r_adr_err <= 1'b1;
        end
    end

    assign vid_ack   = w_vid_gnt;
    assign cpu_ack   = w_cpu_gnt;
    assign vid_valid = r_vid_valid & ~rst;
    assign vid_dat   = vid_valid ? ram_dat_i : '0;
    assign adr_err   = r_adr_err;

`ifdef FB_STALL_STATS_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles the CPU waited with a request pending.
    always_ff @(posedge clk_i) begin
        if (rst || stats_clr) begin
            r_stall_cnt <= '0;
        end else if (cpu_req && !w_cpu_gnt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cpu_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter, built with a 64-pixel framebuffer
// so full clears stay short. Connects the FB_STALL_STATS_EN ports when defined.
module tb_fb_access_arbiter;

    localparam int DEPTH = 64;
    localparam int AW    = 19;
    localparam int DW    = 4;

    typedef struct {
        logic          rst;
        logic          vidReq;
        logic [AW-1:0] vidAdr;
        logic          cpuReq;
        logic [AW-1:0] cpuAdr;
        logic [DW-1:0] cpuDat;
        logic          clrStart;
        logic [DW-1:0] clrColor;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic          expVidAck;
        logic          expCpuAck;
        logic          expWe;
        logic          expRe;
        logic [AW-1:0] expAdr;
        logic [DW-1:0] expDat;
        logic          expValid;
        logic [DW-1:0] expVidDat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          vid_req;
    logic [AW-1:0] vid_adr;
    logic          vid_ack;
    logic          vid_valid;
    logic [DW-1:0] vid_dat;
    logic          cpu_req;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_dat;
    logic          cpu_ack;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic          clr_done;
    logic          adr_err;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_dat_o;
    logic [DW-1:0] ram_dat_i;
`ifdef FB_STALL_STATS_EN
    logic          stats_clr;
    logic [31:0]   cpu_stall_cnt;
    longint        mStall;
`endif

    int checks = 0;
    int errors = 0;

    logic          ramInit;
    logic [DW-1:0] ramMem [DEPTH];

    // Reference state: shadow memory plus the clear job described as "next pixel / colour".
    logic [DW-1:0] mShadow [DEPTH];
    bit            mFilling, mDone, mBusy, mCpuTurn, mAdrErr, mValid, mCpuGranted;
    int            mNext;
    logic [DW-1:0] mColor, mValidData, mLastDat;
    logic [AW-1:0] mLastAdr;

    always #5 clk = ~clk;

    fb_access_arbiter #(
        .WORD_DEPTH(DEPTH),
        .ADR_W     (AW),
        .DAT_W     (DW)
    ) dut (
        .clk_i    (clk),
        .rst      (rst),
        .vid_req  (vid_req),
        .vid_adr  (vid_adr),
        .vid_ack  (vid_ack),
        .vid_valid(vid_valid),
        .vid_dat  (vid_dat),
        .cpu_req  (cpu_req),
        .cpu_adr  (cpu_adr),
        .cpu_dat  (cpu_dat),
        .cpu_ack  (cpu_ack),
        .clr_start(clr_start),
        .clr_color(clr_color),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .adr_err  (adr_err),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .ram_adr  (ram_adr),
        .ram_dat_o(ram_dat_o),
        .ram_dat_i(ram_dat_i)
`ifdef FB_STALL_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .cpu_stall_cnt(cpu_stall_cnt)
`endif
    );

    // Framebuffer RAM with a 1-cycle registered read; preloaded while ramInit is high.
    always @(posedge clk) begin
        if (ramInit) begin
            for (int i = 0; i < DEPTH; i++) ramMem[i] <= DW'((i + 9) % 16);
        end else begin
            if (ram_re) ram_dat_i <= ramMem[ram_adr[5:0]];
            if (ram_we) ramMem[ram_adr[5:0]] <= ram_dat_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic r, input logic vr, input logic [AW-1:0] va,
                                 input logic cr, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                 input logic cs, input logic [DW-1:0] cc);
        stim_t s;
        s.rst = r; s.vidReq = vr; s.vidAdr = va; s.cpuReq = cr;
        s.cpuAdr = ca; s.cpuDat = cd; s.clrStart = cs; s.clrColor = cc;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endfunction

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst       = s.rst;
        vid_req   = s.vidReq;
        vid_adr   = s.vidAdr;
        cpu_req   = s.cpuReq;
        cpu_adr   = s.cpuAdr;
        cpu_dat   = s.cpuDat;
        clr_start = s.clrStart;
        clr_color = s.clrColor;
        #1;
    endtask

    // Compare the DUT against the reference for this cycle, then advance the reference.
    task automatic checkOutput();
        logic          eVid, eCpu, eClr, eWe, inRange;
        logic [AW-1:0] eAdr;
        logic [DW-1:0] eDat;
        if (rst) begin
            chk("rst_vid_ack", 32'(vid_ack), 32'd0);
            chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
            chk("rst_ram_we", 32'(ram_we), 32'd0);
            chk("rst_ram_re", 32'(ram_re), 32'd0);
            mFilling = 0; mDone = 0; mBusy = 0; mCpuTurn = 1; mAdrErr = 0; mValid = 0;
            mNext = 0; mColor = '0; mLastAdr = '0; mLastDat = '0; mCpuGranted = 0;
`ifdef FB_STALL_STATS_EN
            mStall = 0;
`endif
            return;
        end
        eVid = vid_req; eCpu = 0; eClr = 0;
        if (!eVid) begin
            if (cpu_req && mFilling) begin
                if (mCpuTurn) eCpu = 1; else eClr = 1;
            end else if (cpu_req) eCpu = 1;
            else if (mFilling)    eClr = 1;
        end
        inRange = (int'(cpu_adr) < DEPTH);
        eWe  = eClr || (eCpu && inRange);
        eAdr = mLastAdr;
        eDat = mLastDat;
        if (eVid) eAdr = vid_adr;
        else if (eClr) begin eAdr = AW'(mNext); eDat = mColor; end
        else if (eCpu && inRange) begin eAdr = cpu_adr; eDat = cpu_dat; end

        chk("vid_ack", 32'(vid_ack), 32'(eVid));
        chk("cpu_ack", 32'(cpu_ack), 32'(eCpu));
        chk("ram_we", 32'(ram_we), 32'(eWe));
        chk("ram_re", 32'(ram_re), 32'(eVid));
        chk("ram_adr", 32'(ram_adr), 32'(eAdr));
        chk("ram_dat_o", 32'(ram_dat_o), 32'(eDat));
        chk("vid_valid", 32'(vid_valid), 32'(mValid));
        if (mValid) chk("vid_dat", 32'(vid_dat), 32'(mValidData));
        chk("clr_busy", 32'(clr_busy), 32'(mBusy));
        chk("clr_done", 32'(clr_done), 32'(mDone));
        chk("adr_err", 32'(adr_err), 32'(mAdrErr));
`ifdef FB_STALL_STATS_EN
        chk("cpu_stall_cnt", cpu_stall_cnt, 32'(mStall));
        if (stats_clr) mStall = 0;
        else if (cpu_req && !eCpu && mStall < 64'hFFFF_FFFF) mStall++;
`endif

        mCpuGranted = eCpu;
        mLastAdr = eAdr;
        mLastDat = eDat;
        mValid = eVid;
        if (eVid) mValidData = mShadow[vid_adr[5:0]];
        if (eWe) mShadow[eAdr[5:0]] = eDat;
        if (eCpu && !inRange) mAdrErr = 1;
        if (eCpu) mCpuTurn = 0;
        else if (eClr) mCpuTurn = 1;
        if (mDone) begin
            mDone = 0;
        end else if (mFilling) begin
            if (eClr) begin
                mNext++;
                if (mNext == DEPTH) begin mFilling = 0; mBusy = 0; mDone = 1; end
            end
        end else if (clr_start) begin
            mFilling = 1; mBusy = 1; mNext = 0; mColor = clr_color;
        end
    endtask

    task automatic step(input stim_t s);
        applyStimulus(s);
        checkOutput();
    endtask

    task automatic waitDone(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(idle());
            if (clr_done) seen = 1;
            checkOutput();
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    vec_t vecs [9];

    initial begin
        int doneAt;
        int sawDone;
        bit cpuPending;
        logic [AW-1:0] cAdr;
        logic [DW-1:0] cDat;

        // Video burst at 0,1,2 starves a pending CPU write, then CPU/video hazards at address 5 and 9.
        vecs[0] = '{mk(0,1,19'd0,1,19'd9,4'h6,0,4'h0), 1,0,0,1, 19'd0, 4'h0, 0, 4'h0};
        vecs[1] = '{mk(0,1,19'd1,1,19'd9,4'h6,0,4'h0), 1,0,0,1, 19'd1, 4'h0, 1, 4'h9};
        vecs[2] = '{mk(0,1,19'd2,1,19'd9,4'h6,0,4'h0), 1,0,0,1, 19'd2, 4'h0, 1, 4'hA};
        vecs[3] = '{mk(0,0,19'd0,1,19'd9,4'h6,0,4'h0), 0,1,1,0, 19'd9, 4'h6, 1, 4'hB};
        vecs[4] = '{mk(0,0,19'd0,1,19'd5,4'hA,0,4'h0), 0,1,1,0, 19'd5, 4'hA, 0, 4'h0};
        vecs[5] = '{mk(0,1,19'd5,0,19'd0,4'h0,0,4'h0), 1,0,0,1, 19'd5, 4'hA, 0, 4'h0};
        vecs[6] = '{mk(0,0,19'd0,0,19'd0,4'h0,0,4'h0), 0,0,0,0, 19'd5, 4'hA, 1, 4'hA};
        vecs[7] = '{mk(0,1,19'd9,0,19'd0,4'h0,0,4'h0), 1,0,0,1, 19'd9, 4'hA, 0, 4'h0};
        vecs[8] = '{mk(0,0,19'd0,0,19'd0,4'h0,0,4'h0), 0,0,0,0, 19'd9, 4'hA, 1, 4'h6};

        ramInit = 1'b1;
        for (int i = 0; i < DEPTH; i++) mShadow[i] = DW'((i + 9) % 16);
        rst = 1'b1; vid_req = 0; vid_adr = '0; cpu_req = 0; cpu_adr = '0;
        cpu_dat = '0; clr_start = 0; clr_color = '0;
`ifdef FB_STALL_STATS_EN
        stats_clr = 1'b0;
`endif

        $display("[TB] reset");
        step(mk(1,0,'0,0,'0,'0,0,'0));
        ramInit = 1'b0;
        step(mk(1,0,'0,0,'0,'0,0,'0));
        step(idle());

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].s);
            chk($sformatf("vec%0d_vid_ack", i), 32'(vid_ack), 32'(vecs[i].expVidAck));
            chk($sformatf("vec%0d_cpu_ack", i), 32'(cpu_ack), 32'(vecs[i].expCpuAck));
            chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].expWe));
            chk($sformatf("vec%0d_ram_re", i), 32'(ram_re), 32'(vecs[i].expRe));
            chk($sformatf("vec%0d_ram_adr", i), 32'(ram_adr), 32'(vecs[i].expAdr));
            chk($sformatf("vec%0d_ram_dat_o", i), 32'(ram_dat_o), 32'(vecs[i].expDat));
            chk($sformatf("vec%0d_vid_valid", i), 32'(vid_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) chk($sformatf("vec%0d_vid_dat", i), 32'(vid_dat), 32'(vecs[i].expVidDat));
            checkOutput();
        end

        $display("[TB] address range boundary");
        applyStimulus(mk(0,0,'0,1,19'd63,4'h3,0,'0));
        chk("last_adr_ack", 32'(cpu_ack), 32'd1);
        chk("last_adr_we", 32'(ram_we), 32'd1);
        checkOutput();
        applyStimulus(idle());
        chk("last_adr_no_err", 32'(adr_err), 32'd0);
        checkOutput();
        applyStimulus(mk(0,0,'0,1,19'd64,4'h3,0,'0));
        chk("oor_ack", 32'(cpu_ack), 32'd1);
        chk("oor_we", 32'(ram_we), 32'd0);
        checkOutput();
        for (int i = 0; i < 6; i++) step(idle());
        applyStimulus(idle());
        chk("oor_err_sticky", 32'(adr_err), 32'd1);
        checkOutput();
        step(mk(1,0,'0,0,'0,'0,0,'0));
        applyStimulus(idle());
        chk("err_cleared_by_rst", 32'(adr_err), 32'd0);
        checkOutput();

        $display("[TB] clear with CPU held");
        step(mk(0,0,'0,0,'0,'0,1,4'h3));
        doneAt = 0;
        for (int t = 1; t <= 300 && doneAt == 0; t++) begin
            applyStimulus(mk(0,0,'0,1,19'd20,4'hC,0,'0));
            if (t <= 2 * DEPTH) chk("clr_alternate", 32'(cpu_ack), 32'(t % 2));
            if (clr_done) doneAt = t;
            checkOutput();
        end
        chk("clr_done_cycle", 32'(doneAt), 32'(2 * DEPTH + 1));
        for (int a = 0; a <= DEPTH; a++) begin
            applyStimulus(mk(0, a < DEPTH, AW'(a % DEPTH), 0,'0,'0,0,'0));
            if (a > 0) chk("readback", 32'(vid_dat), (a - 1 == 20) ? 32'hC : 32'h3);
            checkOutput();
        end

        $display("[TB] reset during clear");
        step(mk(0,0,'0,0,'0,'0,1,4'h5));
        for (int i = 0; i < 40; i++) step(idle());
        step(mk(1,0,'0,0,'0,'0,0,'0));
        applyStimulus(idle());
        chk("busy_after_rst", 32'(clr_busy), 32'd0);
        checkOutput();
        sawDone = 0;
        for (int i = 0; i < 70; i++) begin
            applyStimulus(idle());
            if (clr_done) sawDone++;
            checkOutput();
        end
        chk("no_done_after_rst", 32'(sawDone), 32'd0);
        step(mk(0,0,'0,0,'0,'0,1,4'h6));
        applyStimulus(idle());
        chk("restart_we", 32'(ram_we), 32'd1);
        chk("restart_adr", 32'(ram_adr), 32'd0);
        chk("restart_dat", 32'(ram_dat_o), 32'h6);
        checkOutput();
        waitDone("restart_done", 200);

        $display("[TB] start ignored during fill");
        step(mk(0,0,'0,0,'0,'0,1,4'h2));
        for (int i = 0; i < 10; i++) step(idle());
        applyStimulus(mk(0,0,'0,0,'0,'0,1,4'h9));
        chk("ignore_adr_before", 32'(ram_adr), 32'd10);
        checkOutput();
        applyStimulus(idle());
        chk("ignore_adr_after", 32'(ram_adr), 32'd11);
        chk("ignore_color", 32'(ram_dat_o), 32'h2);
        chk("ignore_busy", 32'(clr_busy), 32'd1);
        checkOutput();
        waitDone("ignore_done", 200);

        $display("[TB] randomized traffic");
        cpuPending = 0; cAdr = '0; cDat = '0;
        for (int n = 0; n < 3000; n++) begin
            stim_t s;
            if (!cpuPending && $urandom_range(0, 2) == 0) begin
                cpuPending = 1;
                cAdr = ($urandom_range(0, 99) == 0) ? AW'(DEPTH + $urandom_range(0, 1000))
                                                    : AW'($urandom_range(0, DEPTH - 1));
                cDat = DW'($urandom_range(0, 15));
            end
            s = mk($urandom_range(0, 500) == 0, $urandom_range(0, 3) == 0,
                   AW'($urandom_range(0, DEPTH - 1)), cpuPending, cAdr, cDat,
                   $urandom_range(0, 40) == 0, DW'($urandom_range(0, 15)));
`ifdef FB_STALL_STATS_EN
            stats_clr = ($urandom_range(0, 200) == 0);
`endif
            step(s);
            if (mCpuGranted) cpuPending = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
